// File: rtl/secure_strobe_seq.sv
`default_nettype none
// ============================================================================
//  Module   : secure_strobe_seq
//  Purpose  : Timed release sequencer: status deassert, data load, strobe pulse.
//  Revision : 1.0  initial release
// ============================================================================
module secure_strobe_seq #(
   parameter int                DATA_W      = 32,
   parameter int                STATUS_DLY  = 9,
   parameter int                STROBE_DLY  = 5,
   parameter int                STROBE_LEN  = 1,
   parameter logic [DATA_W-1:0] SEC_PATTERN = DATA_W'('hFF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_secure_in,
   input  logic              i_clr,
   input  logic [DATA_W-1:0] i_data_in,
   output logic              o_status,
   output logic              o_strobe,
   output logic              o_secure_out,
   output logic [DATA_W-1:0] o_data,
   output logic              o_busy,
   output logic              o_start_err
);

   localparam int c_max_ab  = (STATUS_DLY > STROBE_DLY) ? STATUS_DLY : STROBE_DLY;
   localparam int c_max_dly = (c_max_ab > STROBE_LEN) ? c_max_ab : STROBE_LEN;
   localparam int CNT_W     = $clog2(c_max_dly + 1);

   localparam logic [CNT_W-1:0] c_stat_end = CNT_W'(STATUS_DLY);
   localparam logic [CNT_W-1:0] c_stb_end  = CNT_W'(STROBE_DLY);
   localparam logic [CNT_W-1:0] c_len_end  = CNT_W'(STROBE_LEN);
   localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_STAT = 3'd1,
      S_WAIT_STB  = 3'd2,
      S_STROBE    = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_payload;
   logic [DATA_W-1:0] r_data;
   logic              r_status;
   logic              r_strobe;
   logic              r_secure;
   logic              r_busy;
   logic              r_start_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_payload   <= '0;
         r_data      <= '0;
         r_status    <= 1'b1;
         r_strobe    <= 1'b0;
         r_secure    <= 1'b0;
         r_busy      <= 1'b0;
         r_start_err <= 1'b0;
      end else begin
         r_start_err <= 1'b0;
         if (i_clr) begin
            // Abort wins over everything; secure data never survives an abort.
            r_state  <= S_IDLE;
            r_status <= 1'b1;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            if (r_secure) begin
               r_data <= '0;
            end
         end else begin
            case (r_state)
               S_IDLE, S_DONE: begin
                  if (i_start) begin
                     r_secure  <= i_secure_in;
                     r_payload <= i_data_in;
                     r_status  <= 1'b1;
                     r_busy    <= 1'b1;
                     r_cnt     <= c_one;
                     r_state   <= S_WAIT_STAT;
                  end
               end
               S_WAIT_STAT: begin
                  r_start_err <= i_start;
                  if (r_cnt == c_stat_end) begin
                     r_status <= 1'b0;
                     r_data   <= r_secure ? SEC_PATTERN : r_payload;
                     r_cnt    <= c_one;
                     r_state  <= S_WAIT_STB;
                  end else begin
                     r_cnt <= r_cnt + c_one;
                  end
               end
               S_WAIT_STB: begin
                  r_start_err <= i_start;
                  if (r_cnt == c_stb_end) begin
                     r_strobe <= 1'b1;
                     r_cnt    <= c_one;
                     r_state  <= S_STROBE;
                  end else begin
                     r_cnt <= r_cnt + c_one;
                  end
               end
               S_STROBE: begin
                  r_start_err <= i_start;
                  if (r_cnt == c_len_end) begin
                     r_strobe <= 1'b0;
                     r_busy   <= 1'b0;
                     r_cnt    <= '0;
                     r_state  <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt + c_one;
                  end
               end
               default: begin
                  r_state  <= S_IDLE;
                  r_status <= 1'b1;
                  r_strobe <= 1'b0;
                  r_busy   <= 1'b0;
                  r_cnt    <= '0;
               end
            endcase
         end
      end
   end

   assign o_status     = r_status;
   assign o_strobe     = r_strobe;
   assign o_secure_out = r_secure;
   assign o_data       = r_data;
   assign o_busy       = r_busy;
   assign o_start_err  = r_start_err;

endmodule
`default_nettype wire

// File: tb/tb_secure_strobe_seq.sv
`default_nettype none
// Bench for secure_strobe_seq: default instance (A) and short-timing instance (B)
// share stimulus; a time-window model predicts every output each cycle.
module tb_secure_strobe_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        secin = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] din = '0;

   logic        a_status, a_strobe, a_sec, a_busy, a_err;
   logic [31:0] a_data;
   logic        b_status, b_strobe, b_sec, b_busy, b_err;
   logic [31:0] b_data;

   int n_chk  = 0;
   int n_pass = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   secure_strobe_seq u_a (
      .clk(clk), .rst(rst), .i_start(start), .i_secure_in(secin), .i_clr(clr),
      .i_data_in(din), .o_status(a_status), .o_strobe(a_strobe),
      .o_secure_out(a_sec), .o_data(a_data), .o_busy(a_busy), .o_start_err(a_err)
   );

   secure_strobe_seq #(.STATUS_DLY(1), .STROBE_DLY(1), .STROBE_LEN(3)) u_b (
      .clk(clk), .rst(rst), .i_start(start), .i_secure_in(secin), .i_clr(clr),
      .i_data_in(din), .o_status(b_status), .o_strobe(b_strobe),
      .o_secure_out(b_sec), .o_data(b_data), .o_busy(b_busy), .o_start_err(b_err)
   );

   typedef struct {
      bit          run;
      int          k;
      logic        sec;
      logic [31:0] pay;
      logic [31:0] data;
      logic        status;
      logic        strobe;
      logic        busy;
      logic        err;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mreset();
      mdl_t m;
      m.run = 0; m.k = 0; m.sec = 0; m.pay = '0; m.data = '0;
      m.status = 1; m.strobe = 0; m.busy = 0; m.err = 0;
      return m;
   endfunction

   // k counts edges since the start edge; every output is a window on k.
   function automatic mdl_t mstep(mdl_t m, int s, int d, int l,
                                  logic st, logic sc, logic cl, logic [31:0] dn);
      mdl_t n = m;
      n.err = 0;
      if (cl) begin
         n.run = 0; n.status = 1; n.strobe = 0; n.busy = 0;
         if (m.sec) n.data = '0;
      end else if (m.run) begin
         n.k   = m.k + 1;
         n.err = st;
         if (n.k == s) begin
            n.status = 0;
            n.data   = m.sec ? 32'hFF : m.pay;
         end
         n.strobe = (n.k >= s + d) && (n.k < s + d + l);
         if (n.k == s + d + l) begin
            n.run = 0; n.busy = 0;
         end
      end else if (st) begin
         n.run = 1; n.k = 0; n.sec = sc; n.pay = dn;
         n.status = 1; n.strobe = 0; n.busy = 1;
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ma = mreset();
         mb = mreset();
      end else begin
         ma = mstep(ma, 9, 5, 1, start, secin, clr, din);
         mb = mstep(mb, 1, 1, 3, start, secin, clr, din);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("a_status", 32'(a_status), 32'(ma.status));
         chk("a_strobe", 32'(a_strobe), 32'(ma.strobe));
         chk("a_secure", 32'(a_sec),    32'(ma.sec));
         chk("a_data",   a_data,        ma.data);
         chk("a_busy",   32'(a_busy),   32'(ma.busy));
         chk("a_err",    32'(a_err),    32'(ma.err));
         chk("b_status", 32'(b_status), 32'(mb.status));
         chk("b_strobe", 32'(b_strobe), 32'(mb.strobe));
         chk("b_secure", 32'(b_sec),    32'(mb.sec));
         chk("b_data",   b_data,        mb.data);
         chk("b_busy",   32'(b_busy),   32'(mb.busy));
         chk("b_err",    32'(b_err),    32'(mb.err));
         if (a_strobe && a_status) chk("a_strobe_vs_status", 32'(1), 32'(0));
         if (b_strobe && b_status) chk("b_strobe_vs_status", 32'(1), 32'(0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_a_status"}, 32'(a_status), 32'(1));
      chk({tag, "_a_strobe"}, 32'(a_strobe), 32'(0));
      chk({tag, "_a_secure"}, 32'(a_sec),    32'(0));
      chk({tag, "_a_data"},   a_data,        32'h0);
      chk({tag, "_a_busy"},   32'(a_busy),   32'(0));
      chk({tag, "_a_err"},    32'(a_err),    32'(0));
      chk({tag, "_b_status"}, 32'(b_status), 32'(1));
      chk({tag, "_b_strobe"}, 32'(b_strobe), 32'(0));
      chk({tag, "_b_data"},   b_data,        32'h0);
      chk({tag, "_b_busy"},   32'(b_busy),   32'(0));
   endtask

   // Hand-derived timeline for the default instance: start at E0, then
   // optional second start sampled at edge err_k and clear sampled at clr_k.
   task automatic run_a(input string tag, input logic sc, input logic [31:0] pay,
                        input logic [31:0] prev, input int err_k, input int clr_k);
      logic [31:0] ed;
      bit ab;
      start = 1; secin = sc; din = pay;
      tick();
      start = 0; din = $urandom;
      for (int k = 1; k <= 20; k++) begin
         start = (k == err_k);
         clr   = (k == clr_k);
         tick();
         start = 0; clr = 0;
         ab = (clr_k > 0) && (k >= clr_k);
         if (k < 9)          ed = prev;
         else if (ab && sc)  ed = 32'h0;
         else                ed = sc ? 32'hFF : pay;
         chk({tag, "_status"}, 32'(a_status), 32'(ab ? 1'b1 : (k < 9)));
         chk({tag, "_strobe"}, 32'(a_strobe), 32'(!ab && k == 14));
         chk({tag, "_busy"},   32'(a_busy),   32'(!ab && k < 15));
         chk({tag, "_err"},    32'(a_err),    32'(k == err_k));
         chk({tag, "_data"},   a_data,        ed);
      end
   endtask

   initial begin
      logic [31:0] p;
      tick();
      tick();
      rst = 0;
      cmp_en = 1;
      chk_reset_vals("rst");

      run_a("t1", 1'b1, $urandom, 32'h0, 0, 0);
      run_a("t2", 1'b0, 32'hA5A5_0001, 32'hFF, 0, 0);

      run_a("t3s", 1'b1, 32'h0BAD_F00D, 32'hA5A5_0001, 0, 0);
      clr = 1; tick(); clr = 0;
      chk("t3s_clr_data",   a_data,        32'h0);
      chk("t3s_clr_status", 32'(a_status), 32'(1));
      chk("t3s_clr_busy",   32'(a_busy),   32'(0));
      chk("t3s_clr_secure", 32'(a_sec),    32'(1));
      run_a("t3p", 1'b0, 32'h1234_5678, 32'h0, 0, 0);
      clr = 1; tick(); clr = 0;
      chk("t3p_clr_data",   a_data,        32'h1234_5678);
      chk("t3p_clr_status", 32'(a_status), 32'(1));

      run_a("t4", 1'b0, 32'hCAFE_0004, 32'h1234_5678, 5, 0);
      run_a("t5", 1'b0, 32'h5555_0005, 32'hCAFE_0004, 0, 12);

      start = 1; clr = 1; secin = 1; tick(); start = 0; clr = 0;
      chk("t5_cs_busy",   32'(a_busy),   32'(0));
      chk("t5_cs_err",    32'(a_err),    32'(0));
      chk("t5_cs_status", 32'(a_status), 32'(1));
      chk("t5_cs_secure", 32'(a_sec),    32'(0));
      tick();
      chk("t5_cs_idle", 32'(a_busy), 32'(0));

      p = 32'h6666_0006;
      start = 1; secin = 0; din = p; tick(); start = 0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("t6_status", 32'(b_status), 32'(0));
         chk("t6_strobe", 32'(b_strobe), 32'(k >= 2 && k <= 4));
         chk("t6_busy",   32'(b_busy),   32'(k < 5));
         chk("t6_data",   b_data,        p);
      end
      start = 1; tick(); start = 0;
      tick(); tick(); tick();
      chk("t6_pre_rst_strobe", 32'(b_strobe), 32'(1));
      #2 rst = 1;
      #1 chk_reset_vals("t6_rst");
      tick();
      rst = 0;

      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 4) == 0);
         secin = 1'($urandom_range(0, 1));
         din   = $urandom;
         clr   = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 399) == 0) begin
            #2 rst = 1;
            tick();
            rst = 0;
         end else begin
            tick();
         end
      end
      start = 0; clr = 0;
      tick();
      cmp_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
